fifo_rr_scheduler: RTL
======================

FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_SRC, 4, number of source FIFOs, 2..16.
REQ-002 SHALL have parameter DATA_W, 32, data width per FIFO word.
REQ-003 SHALL have parameter BURST_MAX, 8, maximum pops per grant, 1..255.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port en, input, 1, scheduler enable.
REQ-007 SHALL have port src_empty, input, NUM_SRC, empty flag of each source FIFO.
REQ-008 SHALL have port src_pop, output, NUM_SRC, pop strobe to each source FIFO.
REQ-009 SHALL have port src_dout, input, NUM_SRC*DATA_W, flattened FIFO read data; source i occupies bits [i*DATA_W +: DATA_W]; valid the cycle after its pop.
REQ-010 SHALL have port m_tdata, output, DATA_W, output stream data.
REQ-011 SHALL have port m_tid, output, $clog2(NUM_SRC), source index of m_tdata.
REQ-012 SHALL have port m_tvalid, output, 1, output word valid.
REQ-013 SHALL have port m_tready, input, 1, downstream accept.
REQ-014 SHALL have port grant_id, output, $clog2(NUM_SRC), currently granted source.
REQ-015 SHALL have port busy, output, 1, high when not IDLE, or occ>0, or inflight=1.

Function
REQ-016 SHALL implement states IDLE and GRANT.
REQ-017 IDLE: if en=1 and any src_empty bit is 0, SHALL load grant_id with the first non-empty index searched upward from rr_ptr with wrap, clear burst_cnt, and enter GRANT next cycle; no pop issued in IDLE.
REQ-018 GRANT: SHALL assert src_pop[grant_id] (one-hot, all other bits 0) when src_empty[grant_id]=0 and (occ + inflight - (m_tvalid & m_tready)) < 2.
REQ-019 Each pop SHALL increment burst_cnt; SHALL set inflight=1 for the following cycle, else 0.
REQ-020 GRANT SHALL exit to IDLE at the cycle after burst_cnt reaches BURST_MAX, or src_empty[grant_id]=1 with no pop issued, or en=0; on exit rr_ptr SHALL become (grant_id+1) mod NUM_SRC.
REQ-021 Deasserting en SHALL NOT discard inflight or buffered words; they SHALL drain normally.
REQ-022 Word arriving the cycle after a pop SHALL be captured with its source index into a 2-entry in-order skid buffer; occ SHALL range 0..2 and never overflow.
REQ-023 m_tvalid SHALL equal (occ>0); m_tdata/m_tid SHALL present the oldest entry; transfer occurs when m_tvalid & m_tready.
REQ-024 Simultaneous capture and transfer SHALL keep occ unchanged and preserve order.
REQ-025 With m_tready held 1 and source non-empty, SHALL sustain one word per cycle within a grant; one bubble cycle (IDLE) between grants.
REQ-026 m_tdata/m_tid SHALL hold stable while m_tvalid=1 and m_tready=0.
REQ-027 Words SHALL leave in pop order; no word popped SHALL be lost or duplicated.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, occ=0, inflight=0, src_pop=0, m_tvalid=0, m_tdata=0, m_tid=0, busy=0.
REQ-029 Reset mid-burst SHALL discard buffered and inflight data; first grant after release SHALL search from index 0.

Verification
REQ-030 All four sources holding 3 words, BURST_MAX=8, m_tready=1 -> m_tid sequence 0,0,0,1,1,1,2,2,2,3,3,3 with one bubble between grants.
REQ-031 Source 2 holding 20 words, others empty, BURST_MAX=8 -> bursts of 8,8,4 words all with m_tid=2, each separated by one IDLE cycle.
REQ-032 Source 1 streaming, m_tready toggling 1,0,0,1 -> occ never exceeds 2, src_pop suppressed when full, output data matches input order exactly.
REQ-033 en dropped mid-burst after 3 pops -> no further pops, already-popped words all delivered, state IDLE, busy falls after last transfer.
REQ-034 rst asserted asynchronously with occ=2 -> m_tvalid and src_pop 0 before next clock edge; after release, source 0 granted first if non-empty.

Source files
------------

// File: rtl/fifo_rr_scheduler.sv
// Round-robin burst scheduler: pops up to BURST_MAX words per grant from one of
// NUM_SRC source FIFOs and streams them out through a 2-entry in-order skid buffer.
module fifo_rr_scheduler #(
   parameter int NUM_SRC   = 4,
   parameter int DATA_W    = 32,
   parameter int BURST_MAX = 8,
   localparam int ID_W     = $clog2(NUM_SRC)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [NUM_SRC-1:0]        src_empty,
   output logic [NUM_SRC-1:0]        src_pop,
   input  logic [NUM_SRC*DATA_W-1:0] src_dout,
   output logic [DATA_W-1:0]         m_tdata,
   output logic [ID_W-1:0]           m_tid,
   output logic                      m_tvalid,
   input  logic                      m_tready,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t              state, state_nxt;
   logic [ID_W-1:0]     rr_ptr, rr_nxt, grant_nxt, search_id, inflight_id;
   logic                search_hit;
   logic [7:0]          burst_cnt, burst_nxt;
   logic [1:0]          occ;
   logic                inflight;
   logic                pop, xfer, room;
   logic [2:0]          pend;
   logic [DATA_W-1:0]   dout_arr [NUM_SRC];
   logic [DATA_W-1:0]   cap_data;
   logic [DATA_W-1:0]   data_p0, data_p1;
   logic [ID_W-1:0]     id_p0, id_p1;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_dout
      assign dout_arr[g] = src_dout[g*DATA_W +: DATA_W];
   end

   assign cap_data = dout_arr[inflight_id];
   assign xfer     = m_tvalid & m_tready;
   // Words already committed to the buffer after this cycle's transfer.
   assign pend     = 3'(occ) + 3'(inflight) - 3'(xfer);
   assign room     = (pend < 3'd2);

   always_comb begin
      logic [ID_W-1:0] idx;
      search_hit = 1'b0;
      search_id  = rr_ptr;
      idx        = '0;
      // Scan downward so the lowest offset from rr_ptr wins.
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         idx = ID_W'((int'(rr_ptr) + k) % NUM_SRC);
         if (!src_empty[idx]) begin
            search_hit = 1'b1;
            search_id  = idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant_id;
      burst_nxt = burst_cnt;
      rr_nxt    = rr_ptr;
      pop       = 1'b0;
      unique case (state)
         IDLE: begin
            if (en && search_hit) begin
               grant_nxt = search_id;
               burst_nxt = '0;
               state_nxt = GRANT;
            end
         end
         GRANT: begin
            if (!en || src_empty[grant_id]) begin
               state_nxt = IDLE;
            end else if (room) begin
               pop       = 1'b1;
               burst_nxt = burst_cnt + 8'd1;
               if (burst_nxt == 8'(BURST_MAX)) state_nxt = IDLE;
            end
            if (state_nxt == IDLE)
               rr_nxt = (grant_id == ID_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      src_pop = '0;
      if (pop) src_pop[grant_id] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rr_ptr      <= '0;
         grant_id    <= '0;
         burst_cnt   <= '0;
         inflight    <= 1'b0;
         inflight_id <= '0;
      end else begin
         state       <= state_nxt;
         rr_ptr      <= rr_nxt;
         grant_id    <= grant_nxt;
         burst_cnt   <= burst_nxt;
         inflight    <= pop;
         inflight_id <= grant_id;
      end
   end

   // Skid buffer stage: entry p0 is the oldest word, p1 the younger one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ     <= '0;
         data_p0 <= '0;
         data_p1 <= '0;
         id_p0   <= '0;
         id_p1   <= '0;
      end else if (inflight && xfer) begin
         if (occ == 2'd2) begin
            data_p0 <= data_p1;
            id_p0   <= id_p1;
            data_p1 <= cap_data;
            id_p1   <= inflight_id;
         end else begin
            data_p0 <= cap_data;
            id_p0   <= inflight_id;
         end
      end else if (xfer) begin
         data_p0 <= data_p1;
         id_p0   <= id_p1;
         occ     <= occ - 2'd1;
      end else if (inflight) begin
         if (occ == 2'd0) begin
            data_p0 <= cap_data;
            id_p0   <= inflight_id;
         end else begin
            data_p1 <= cap_data;
            id_p1   <= inflight_id;
         end
         occ <= occ + 2'd1;
      end
   end

   assign m_tvalid = (occ != 2'd0);
   assign m_tdata  = data_p0;
   assign m_tid    = id_p0;
   assign busy     = (state != IDLE) || (occ != 2'd0) || inflight;

endmodule
